// File: rtl/async_fifo_pkg.sv
// Shared defaults for the single-clock FIFO (historically named async_fifo).
package async_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
endpackage

// File: rtl/async_fifo_if.sv
// Producer/consumer bundle for the FIFO; the master drives requests, the slave answers with flags and data.
// A write is accepted on a rising edge where winc=1 and wfull=0; a read where rinc=1 and rempty=0.
interface async_fifo_if
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wfull;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rempty;

  modport master (output winc, wdata, rinc, input wfull, rdata, rempty);
  modport slave  (input winc, wdata, rinc, output wfull, rdata, rempty);
endinterface

// File: rtl/async_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write, registered read with enable.
// Only the read-data register is reset; the array keeps its contents.
module async_fifo_mem
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO: wrap-bit pointers, combinational full/empty flags, registered read data.
// The name is kept for compatibility with the existing integration; there is one clock domain.
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input logic         clk,
  input logic         rst,
  async_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH:0]   r_wptr;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_wen;
  logic                  w_ren;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Equal low bits with differing wrap bits means the writer is one lap ahead.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]) &&
                   (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]);

  assign w_wen = bus.winc & ~w_full  & ~rst;
  assign w_ren = bus.rinc & ~w_empty & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wen) r_wptr <= r_wptr + PTR_ONE;
      if (w_ren) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  async_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_we   (w_wen),
    .i_waddr(r_wptr[ADDR_WIDTH-1:0]),
    .i_wdata(bus.wdata),
    .i_re   (w_ren),
    .i_raddr(r_rptr[ADDR_WIDTH-1:0]),
    .o_rdata(w_rdata)
  );

  assign bus.wfull  = w_full;
  assign bus.rempty = w_empty;
  assign bus.rdata  = w_rdata;
endmodule

// File: tb/tb_async_fifo.sv
// Bench for async_fifo: directed phases plus random traffic against a queue-based FIFO model.
module tb_async_fifo;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst;
  async_fifo_if #(.DATA_WIDTH(DW)) bus ();

  async_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_rdata;
  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, update the model, compare just after the edge.
  task automatic step(input logic r, input logic w, input logic [DW-1:0] d, input logic rd);
    bit do_w;
    bit do_r;
    rst       = r;
    bus.winc  = w;
    bus.wdata = d;
    bus.rinc  = rd;
    do_w = w  && (exp_q.size() < DEPTH);
    do_r = rd && (exp_q.size() > 0);
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      exp_rdata = '0;
    end else begin
      if (do_r) exp_rdata = exp_q.pop_front();
      if (do_w) exp_q.push_back(d);
    end
    #1;
    check("rempty", 32'(bus.rempty), 32'(exp_q.size() == 0));
    check("wfull",  32'(bus.wfull),  32'(exp_q.size() == DEPTH));
    check("rdata",  32'(bus.rdata),  32'(exp_rdata));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    step(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    exp_rdata = '0;
    rst       = 1'b0;
    bus.winc  = 1'b0;
    bus.wdata = '0;
    bus.rinc  = 1'b0;

    // Reset with both requests high: reset must win.
    step(1'b1, 1'b1, 8'h5A, 1'b1);

    // Fill, overflow attempt, drain, underflow.
    for (int i = 0; i < DEPTH; i++) wr(8'(i));
    wr(8'hAA);
    wr(8'hAA);
    step(1'b0, 1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < DEPTH; i++) rd();
    rd();
    rd();
    check("underflow_hold", 32'(bus.rdata), 32'h0F);

    // Wrap with interleaved traffic.
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) wr(8'(i + 1));
    for (int i = 0; i < 10; i++) rd();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'(8'h20 + i), 1'(i % 2));
    while (exp_q.size() > 0) rd();

    // Simultaneous access with 5 held keeps occupancy.
    for (int i = 0; i < 5; i++) wr(8'(8'h40 + i));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h50 + i), 1'b1);
    check("occ5", 32'(exp_q.size()), 32'd5);
    while (exp_q.size() > 0) rd();

    // Empty with both requests: only the write lands.
    step(1'b0, 1'b1, 8'h77, 1'b1);
    rd();

    // Mid-operation reset with 8 entries held.
    for (int i = 0; i < 8; i++) wr(8'(8'h60 + i));
    step(1'b1, 1'b0, '0, 1'b0);
    rd();

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 99) < 55),
           8'($urandom_range(0, 255)),
           1'($urandom_range(0, 99) < 50));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
